pipeline_hold_controller: RTL

PIPELINE_HOLD_CONTROLLER -- requirements
Module: pipeline_hold_controller

---
 rtl/pipeline_hold_controller_if.sv | 30 +++
 rtl/pipeline_hold_controller.sv | 121 ++++++++++++
 2 files changed

// File: rtl/pipeline_hold_controller_if.sv
// Front-end hold/flush bus between the pipeline stages and the hold controller.
// The slave side is the controller; the master side is the pipeline driving events.
interface pipeline_hold_controller_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 fetchCacheMissStall_i;
    logic                 refillDone_i;
    logic                 regFileStall_i;
    logic                 branchFlush_i;
    logic                 perfClear_i;
    logic                 fetchTagQueryStall_o;
    logic                 fetchFullStall_o;
    logic                 decodeStall_o;
    logic                 flush_o;
    logic [1:0]           state_o;
    logic                 missTimeout_o;
    logic [CNT_WIDTH-1:0] stallCount_o;

    modport master (
        output fetchCacheMissStall_i, refillDone_i, regFileStall_i, branchFlush_i, perfClear_i,
        input  fetchTagQueryStall_o, fetchFullStall_o, decodeStall_o, flush_o,
        input  state_o, missTimeout_o, stallCount_o
    );

    modport slave (
        input  fetchCacheMissStall_i, refillDone_i, regFileStall_i, branchFlush_i, perfClear_i,
        output fetchTagQueryStall_o, fetchFullStall_o, decodeStall_o, flush_o,
        output state_o, missTimeout_o, stallCount_o
    );
endinterface

// File: rtl/pipeline_hold_controller.sv
// Front-end hold controller: sequences cache-miss and register-file hazard stalls,
// branch flushes, a sticky miss timeout and a saturating stall-cycle counter.
module pipeline_hold_controller #(
    parameter int MISS_TIMEOUT = 64,
    parameter int CNT_WIDTH    = 16
) (
    input logic                      clock_i,
    input logic                      reset_i,
    pipeline_hold_controller_if.slave bus
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MISS   = 2'd1,
        REPLAY = 2'd2,
        HAZARD = 2'd3
    } state_t;

    localparam int TIMER_W = $clog2(MISS_TIMEOUT + 1);

    state_t               state_r;
    state_t               next_state_s;
    logic [TIMER_W-1:0]   miss_timer_r;
    logic                 tag_stall_r;
    logic                 full_stall_r;
    logic                 decode_stall_r;
    logic                 flush_r;
    logic                 timeout_r;
    logic [CNT_WIDTH-1:0] stall_count_r;

    // Flush beats everything; REPLAY behaves like RUN for its single cycle.
    function automatic state_t next_state_f(
        input state_t cur,
        input logic   flush,
        input logic   miss,
        input logic   refill,
        input logic   regfile
    );
        state_t ns;
        ns = RUN;
        if (flush) begin
            ns = RUN;
        end else begin
            case (cur)
                RUN, REPLAY: begin
                    if (miss)         ns = MISS;
                    else if (regfile) ns = HAZARD;
                    else              ns = RUN;
                end
                MISS: begin
                    if (refill) ns = REPLAY;
                    else        ns = MISS;
                end
                HAZARD: begin
                    if (miss)          ns = MISS;
                    else if (!regfile) ns = RUN;
                    else               ns = HAZARD;
                end
                default: ns = RUN;
            endcase
        end
        return ns;
    endfunction

    assign next_state_s = next_state_f(state_r, bus.branchFlush_i, bus.fetchCacheMissStall_i,
                                       bus.refillDone_i, bus.regFileStall_i);

    // State register, Moore-decoded stall outputs, flush pulse, timer and counters.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r        <= RUN;
            tag_stall_r    <= 1'b0;
            full_stall_r   <= 1'b0;
            decode_stall_r <= 1'b0;
            flush_r        <= 1'b0;
            timeout_r      <= 1'b0;
            miss_timer_r   <= '0;
            stall_count_r  <= '0;
        end else begin
            state_r        <= next_state_s;
            tag_stall_r    <= (next_state_s == MISS);
            full_stall_r   <= (next_state_s == HAZARD);
            decode_stall_r <= (next_state_s == HAZARD);
            flush_r        <= bus.branchFlush_i;

            // Outside MISS the timer sits at zero, so every MISS entry starts fresh.
            if (state_r != MISS) begin
                miss_timer_r <= '0;
            end else if (miss_timer_r != TIMER_W'(MISS_TIMEOUT)) begin
                miss_timer_r <= miss_timer_r + TIMER_W'(1);
            end else begin
                miss_timer_r <= miss_timer_r;
            end

            // Set only on the cycle the timer reaches the limit, so a clear mid-miss sticks.
            if (bus.perfClear_i) begin
                timeout_r <= 1'b0;
            end else if ((state_r == MISS) && (miss_timer_r == TIMER_W'(MISS_TIMEOUT - 1))) begin
                timeout_r <= 1'b1;
            end else begin
                timeout_r <= timeout_r;
            end

            if (bus.perfClear_i) begin
                stall_count_r <= '0;
            end else if (((state_r == MISS) || (state_r == HAZARD)) &&
                         (stall_count_r != {CNT_WIDTH{1'b1}})) begin
                stall_count_r <= stall_count_r + CNT_WIDTH'(1);
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

    assign bus.fetchTagQueryStall_o = tag_stall_r;
    assign bus.fetchFullStall_o     = full_stall_r;
    assign bus.decodeStall_o        = decode_stall_r;
    assign bus.flush_o              = flush_r;
    assign bus.state_o              = state_r;
    assign bus.missTimeout_o        = timeout_r;
    assign bus.stallCount_o         = stall_count_r;
endmodule
